// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue_pkg
// Brief   : Shared defaults, entry-width helper and fire encoding for the
//           instruction fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_queue_pkg;

    localparam int unsigned c_DEF_DEPTH   = 4;
    localparam int unsigned c_DEF_PC_W    = 32;
    localparam int unsigned c_DEF_INSTR_W = 32;

    // Entry packing is {pc, instr}, matching the IF->ID stage data layout
    function automatic int unsigned fq_data_w(input int unsigned pc_w,
                                              input int unsigned instr_w);
        return pc_w + instr_w;
    endfunction

    typedef enum logic [1:0] {
        FIRE_NONE = 2'b00,
        FIRE_DEQ  = 2'b01,
        FIRE_ENQ  = 2'b10,
        FIRE_BOTH = 2'b11
    } fire_e;

endpackage : if_fetch_queue_pkg
`default_nettype wire

// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue_if
// Brief   : Fetch-side and decode-side handshake bundle of the fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = c_DEF_DEPTH,
    parameter int unsigned PC_W    = c_DEF_PC_W,
    parameter int unsigned INSTR_W = c_DEF_INSTR_W
) ();

    logic                     fs_valid;
    logic [PC_W-1:0]          fs_pc;
    logic [INSTR_W-1:0]       fs_instr;
    logic                     fq_allow_in;
    logic                     flush;
    logic                     fq_valid;
    logic [PC_W-1:0]          fq_pc;
    logic [INSTR_W-1:0]       fq_instr;
    logic                     ds_allow_in;
    logic [$clog2(DEPTH):0]   fq_count;

    // Driver side: IF stage, branch controller and fs_ds_reg
    modport master (
        output fs_valid, fs_pc, fs_instr, flush, ds_allow_in,
        input  fq_allow_in, fq_valid, fq_pc, fq_instr, fq_count
    );

    modport slave (
        input  fs_valid, fs_pc, fs_instr, flush, ds_allow_in,
        output fq_allow_in, fq_valid, fq_pc, fq_instr, fq_count
    );

endinterface : if_fetch_queue_if
`default_nettype wire

// File: rtl/if_fetch_queue_fq_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fq_ptr_ctrl
// Brief   : Read/write pointers, occupancy counter and fire logic of the
//           fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
module fq_ptr_ctrl
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEF_DEPTH
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       i_fs_valid,
    input  wire logic                       i_flush,
    input  wire logic                       i_ds_allow_in,
    output logic [$clog2(DEPTH)-1:0]        o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0]        o_rd_ptr,
    output logic [$clog2(DEPTH):0]          o_count,
    output logic                            o_allow_in,
    output logic                            o_valid,
    output logic                            o_enq
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_deq;
    fire_e              w_fire;

    // allow_in depends on registered count only: a full queue never accepts
    // in the same cycle it drains
    assign o_allow_in = (r_count != c_FULL);
    assign o_valid    = (r_count != '0) & ~i_flush;
    assign o_enq      = i_fs_valid & o_allow_in & ~i_flush;
    assign w_deq      = o_valid & i_ds_allow_in;
    assign w_fire     = fire_e'({o_enq, w_deq});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (w_fire)
                FIRE_ENQ: begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    r_count  <= r_count + c_CNT_W'(1);
                end
                FIRE_DEQ: begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                    r_count  <= r_count - c_CNT_W'(1);
                end
                FIRE_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule : fq_ptr_ctrl
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue
// Brief   : DEPTH-entry {pc, instr} queue between IF and fs_ds_reg with
//           valid/allow_in handshakes and branch flush.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = c_DEF_DEPTH,
    parameter int unsigned PC_W    = c_DEF_PC_W,
    parameter int unsigned INSTR_W = c_DEF_INSTR_W
) (
    input  wire logic         clk,
    input  wire logic         reset,
    if_fetch_queue_if.slave   bus
);

    localparam int unsigned c_DATA_W = fq_data_w(PC_W, INSTR_W);
    localparam int unsigned c_PTR_W  = $clog2(DEPTH);

    logic [c_DATA_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]     w_wr_ptr;
    logic [c_PTR_W-1:0]     w_rd_ptr;
    logic [c_PTR_W:0]       w_count;
    logic                   w_allow_in;
    logic                   w_valid;
    logic                   w_enq;
    logic [c_DATA_W-1:0]    w_head;

    fq_ptr_ctrl #(
        .DEPTH          (DEPTH)
    ) u_ptr_ctrl (
        .clk            (clk),
        .reset          (reset),
        .i_fs_valid     (bus.fs_valid),
        .i_flush        (bus.flush),
        .i_ds_allow_in  (bus.ds_allow_in),
        .o_wr_ptr       (w_wr_ptr),
        .o_rd_ptr       (w_rd_ptr),
        .o_count        (w_count),
        .o_allow_in     (w_allow_in),
        .o_valid        (w_valid),
        .o_enq          (w_enq)
    );

    // Storage is cleared on reset so the head outputs are never X
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enq) begin
            r_mem[w_wr_ptr] <= {bus.fs_pc, bus.fs_instr};
        end
    end

    assign w_head          = r_mem[w_rd_ptr];
    assign bus.fq_pc       = w_head[c_DATA_W-1:INSTR_W];
    assign bus.fq_instr    = w_head[INSTR_W-1:0];
    assign bus.fq_valid    = w_valid;
    assign bus.fq_allow_in = w_allow_in;
    assign bus.fq_count    = w_count;

endmodule : if_fetch_queue
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_queue
// Brief   : Scoreboard-driven directed bench for if_fetch_queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int unsigned c_DEPTH   = 4;
    localparam int unsigned c_PC_W    = 32;
    localparam int unsigned c_INSTR_W = 32;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic        fired;

    if_fetch_queue_if #(.DEPTH(c_DEPTH), .PC_W(c_PC_W), .INSTR_W(c_INSTR_W)) bus ();

    if_fetch_queue #(
        .DEPTH   (c_DEPTH),
        .PC_W    (c_PC_W),
        .INSTR_W (c_INSTR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks outputs against the model at the negedge, then commits the
    // cycle's model update and returns 1 ns after the rising edge
    task automatic cyc();
        logic m_allow, m_valid, m_enq;
        @(negedge clk);
        m_allow = (sb.size() != c_DEPTH);
        m_valid = (sb.size() != 0) && !bus.flush;
        chk("count",       64'(bus.fq_count),    64'(sb.size()));
        chk("count_bound", 64'(bus.fq_count <= 3'(c_DEPTH)), 64'd1);
        chk("allow_in",    64'(bus.fq_allow_in), 64'(m_allow));
        chk("valid",       64'(bus.fq_valid),    64'(m_valid));
        if (m_valid) begin
            chk("head_pc",    64'(bus.fq_pc),    64'(sb[0][63:32]));
            chk("head_instr", 64'(bus.fq_instr), 64'(sb[0][31:0]));
        end
        m_enq = bus.fs_valid && m_allow && !bus.flush;
        fired = m_enq;
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (m_valid && bus.ds_allow_in) void'(sb.pop_front());
            if (m_enq) sb.push_back({bus.fs_pc, bus.fs_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.fs_valid = 1'b1;
        bus.fs_pc    = pc;
        bus.fs_instr = pc ^ 32'h0000_0013;
    endtask

    initial begin
        reset           = 1'b0;
        bus.fs_valid    = 1'b0;
        bus.fs_pc       = '0;
        bus.fs_instr    = '0;
        bus.flush       = 1'b0;
        bus.ds_allow_in = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_pc",    64'(bus.fq_pc),    64'd0);
        chk("reset_instr", 64'(bus.fq_instr), 64'd0);
        cyc();

        // Single pass
        bus.ds_allow_in = 1'b1;
        bus.fs_valid = 1'b1; bus.fs_pc = 32'h0; bus.fs_instr = 32'h0000_0013;
        cyc();
        bus.fs_valid = 1'b0;
        cyc();
        cyc();

        // Fill and stall, then a held 5th fetch
        bus.ds_allow_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            cyc();
        end
        fetch(32'h10);
        repeat (2) cyc();
        bus.ds_allow_in = 1'b1;
        for (int i = 0; i < 10 && bus.fs_valid; i++) begin
            cyc();
            if (fired) bus.fs_valid = 1'b0;
        end
        chk("fetch10_accepted", 64'(bus.fs_valid), 64'd0);
        repeat (6) cyc();

        // Concurrent enq/deq streaming with pointer wrap
        for (int i = 0; i < 12; i++) begin
            fetch(32'h100 + 32'(i * 4));
            cyc();
        end
        bus.fs_valid = 1'b0;
        repeat (2) cyc();

        // Flush colliding with a fetch and a dequeue request
        bus.ds_allow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h20 + 32'(i * 4));
            cyc();
        end
        bus.fs_valid = 1'b0;
        cyc();
        bus.flush = 1'b1;
        bus.ds_allow_in = 1'b1;
        fetch(32'h40);
        cyc();
        bus.flush = 1'b0;
        bus.fs_valid = 1'b0;
        bus.ds_allow_in = 1'b0;
        cyc();
        fetch(32'h80);
        cyc();
        bus.fs_valid = 1'b0;
        bus.ds_allow_in = 1'b1;
        cyc();
        cyc();

        // Asynchronous reset between clock edges
        bus.ds_allow_in = 1'b0;
        fetch(32'hA0); cyc();
        fetch(32'hA4); cyc();
        bus.fs_valid = 1'b0;
        chk("pre_reset_count", 64'(bus.fq_count), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 64'(bus.fq_valid), 64'd0);
        chk("async_count", 64'(bus.fq_count), 64'd0);
        chk("async_allow", 64'(bus.fq_allow_in), 64'd1);
        sb.delete();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_queue
`default_nettype wire
